onehot_mux_pipe: RTL and testbench
==================================

ONEHOT_MUX_PIPE -- requirements
Module: onehot_mux_pipe

Interface
REQ-001 Parameter N, default 4, number of data inputs (legal 2..16).
REQ-002 Parameter W, default 32, data width in bits (legal 1..64).
REQ-003 Parameter MODE, default 0, select mode: 0 = AND-OR merge, 1 = lowest-index-wins priority.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port in_data  input  N*W  flattened inputs; input i occupies bits [i*W+W-1 : i*W].
REQ-007 Port onehot  input  N  select vector, one bit per input.
REQ-008 Port in_valid  input  1  upstream beat present.
REQ-009 Port in_ready  output  1  block accepts a beat this cycle.
REQ-010 Port out_data  output  W  selected data of the head beat.
REQ-011 Port out_valid  output  1  head beat present.
REQ-012 Port out_ready  input  1  downstream accepts the head beat.
REQ-013 Port out_err  output  1  head beat's select was not exactly one-hot.
REQ-014 Port err_sticky  output  1  set by any accepted beat with a bad select.
REQ-015 Port err_cnt  output  8  saturating count of accepted bad-select beats.
REQ-016 Port clr_err  input  1  synchronous clear of err_sticky and err_cnt.

Function
REQ-017 Beat accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-018 Select computed combinationally on the input side and captured together with the select-error flag; latency input-accept to out_valid is exactly 1 cycle.
REQ-019 MODE 0: out_data = OR over i of (input i AND onehot[i] replicated W times).
REQ-020 MODE 1: out_data = input of the lowest set index of onehot.
REQ-021 Zero-hot select: out_data = 0 in both modes, out_err = 1.
REQ-022 Multi-hot select: out_data per REQ-019/020, out_err = 1; exactly one-hot: out_err = 0.
REQ-023 Two-entry elastic buffer with states EMPTY, ONE, TWO; in_ready = (state != TWO) and rst deasserted.
REQ-024 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-025 ONE: accept with deliver -> ONE (head replaced); accept without deliver -> TWO (beat into skid); deliver without accept -> EMPTY; neither -> ONE.
REQ-026 TWO: deliver -> ONE, skid entry moves to head the same edge; no deliver -> TWO; no accept possible.
REQ-027 out_data, out_err stable while out_valid && !out_ready; beat order preserved, no beat dropped or duplicated.
REQ-028 Full throughput: one beat per cycle sustained when out_ready held high.
REQ-029 err_cnt increments by 1 per accepted bad-select beat, saturates at 255, never wraps.
REQ-030 err_sticky set on the edge after an accepted bad-select beat; cleared only by clr_err or rst.
REQ-031 clr_err simultaneous with an accepted bad-select beat: err_cnt = 1, err_sticky = 1 next cycle.
REQ-032 Error counting happens at accept time, independent of downstream stall.

Reset
REQ-033 rst asserted: state EMPTY, out_valid = 0, out_data = 0, out_err = 0, err_sticky = 0, err_cnt = 0, in_ready = 0, effective immediately without a clock edge.
REQ-034 Reset mid-operation discards both buffered beats; first accept possible on the first rising edge after rst deasserts.

Structure
REQ-035 Package onehot_mux_pkg holds the state enum (EMPTY/ONE/TWO), MODE encodings and ERR_CNT_W = 8.
REQ-036 Sub-module onehot_sel (combinational: N, W, MODE parameters; in_data, onehot -> sel_data, sel_err) instantiated once on the input side.
REQ-037 No latches; all storage in flops reset by rst.

Verification
REQ-038 N=4, W=32, MODE 0; onehot=0010, in1=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_err=0.
REQ-039 MODE 0 onehot=0101, in0=0x0F, in2=0xF0 -> out_data=0xFF, out_err=1, err_cnt=1; MODE 1 same stimulus -> out_data=0x0F, out_err=1.
REQ-040 onehot=0000 -> out_data=0, out_err=1; 300 such beats -> err_cnt=255, err_sticky=1; clr_err pulse -> both 0.
REQ-041 Stream beats A,B,C with out_ready=0 -> A held on out_data, B in skid, in_ready=0; out_ready=1 -> A,B,C delivered in order, one per cycle.
REQ-042 rst pulsed while state TWO -> out_valid=0, err_cnt=0 immediately; post-reset beat D delivered alone, 1 cycle after accept.

Source files
------------

// File: rtl/onehot_mux_pipe_pkg.sv
// Shared types and constants for the one-hot mux pipeline.
package onehot_mux_pkg;

    // Occupancy of the two-entry elastic buffer (head + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Select-mode encodings for the MODE parameter.
    localparam int MODE_ANDOR = 0;  // OR of all enabled inputs
    localparam int MODE_PRIO  = 1;  // lowest set index wins

    // Bad-select counter width and its saturation value.
    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/onehot_mux_pipe_if.sv
// Stream bus of the one-hot mux pipeline: input beat side and output beat side.
interface onehot_mux_pipe_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   onehot;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_err;

    // Producer/consumer environment around the block.
    modport master (
        output in_data, onehot, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_err
    );

    // The block itself.
    modport slave (
        input  in_data, onehot, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_err
    );
endinterface

// File: rtl/onehot_mux_pipe_sel.sv
// Combinational one-hot selector: picks a data word and flags a select that is
// not exactly one-hot (zero-hot or multi-hot).
module onehot_sel
    import onehot_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = MODE_ANDOR
) (
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   onehot,
    output logic [W-1:0]   sel_data,
    output logic           sel_err
);

    assign sel_err = ($countones(onehot) != 1);

    if (MODE == MODE_PRIO) begin : g_prio
        // Scan from the top down so the lowest set index is the last writer.
        always_comb begin
            // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
            sel_data = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (onehot[i]) sel_data = in_data[i*W +: W];
            end
        end
    end else begin : g_andor
        // AND each input with its replicated select bit, then OR everything together.
        always_comb begin
            sel_data = '0;
            for (int i = 0; i < N; i++) begin
                sel_data = sel_data | (in_data[i*W +: W] & {W{onehot[i]}});
            end
        end
    end

endmodule

// File: rtl/onehot_mux_pipe.sv
// One-hot mux with a two-entry elastic output buffer and bad-select error
// accounting. Selection happens on the input side; the selected word and its
// error flag are what get buffered.
module onehot_mux_pipe
    import onehot_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = MODE_ANDOR
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_mux_pipe_if.slave     bus,
    input  logic                 clr_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [W-1:0]         r_head_data;
    logic                 r_head_err;
    logic [W-1:0]         r_skid_data;
    logic                 r_skid_err;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [W-1:0]         w_sel_data;
    logic                 w_sel_err;
    logic                 w_accept;
    logic                 w_deliver;
    logic                 w_head_from_in;
    logic                 w_head_from_skid;
    logic                 w_skid_load;

    onehot_sel #(
        .N    (N),
        .W    (W),
        .MODE (MODE)
    ) u_sel (
        .in_data  (bus.in_data),
        .onehot   (bus.onehot),
        .sel_data (w_sel_data),
        .sel_err  (w_sel_err)
    );

    // in_ready is also held low while rst is asserted, without waiting for a clock.
    assign bus.in_ready  = (r_state != TWO) && !rst;
    assign bus.out_valid = (r_state != EMPTY);
    assign bus.out_data  = r_head_data;
    assign bus.out_err   = r_head_err;
    assign err_sticky    = r_err_sticky;
    assign err_cnt       = r_err_cnt;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_deliver = bus.out_valid && bus.out_ready;

    // Buffer occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Next occupancy and which storage slot loads on this edge.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_head_from_in = 1'b1;
                    w_state_nxt    = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_deliver) begin
                    w_head_from_in = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = TWO;
                end else if (w_deliver) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_deliver) begin
                    w_head_from_skid = 1'b1;
                    w_state_nxt      = ONE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Head and skid storage for the buffered beats.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data slots are reset too, so out_data reads zero during reset rather than a stale beat.
        if (rst) begin
            r_head_data <= '0;
            r_head_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_head_from_in) begin
                r_head_data <= w_sel_data;
                r_head_err  <= w_sel_err;
            end else if (w_head_from_skid) begin
                r_head_data <= r_skid_data;
                r_head_err  <= r_skid_err;
            end
            if (w_skid_load) begin
                r_skid_data <= w_sel_data;
                r_skid_err  <= w_sel_err;
            end
        end
    end

    // Error accounting at accept time; a bad beat in the clear cycle counts as the first after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_accept && w_sel_err) begin
            r_err_sticky <= 1'b1;
            if (clr_err)                       r_err_cnt <= ERR_CNT_W'(1);
            else if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Directed bench for onehot_mux_pipe: scoreboard on the MODE 0 instance, a
// MODE 1 instance sharing the same stimulus for the priority-select case.
module tb_onehot_mux_pipe;
    import onehot_mux_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } beat_t;

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b1;
    logic                 clr_err = 1'b0;
    logic                 err_sticky0, err_sticky1;
    logic [ERR_CNT_W-1:0] err_cnt0, err_cnt1;

    int    total = 0;
    int    bad   = 0;
    beat_t sb_q[$];

    onehot_mux_pipe_if #(.N(N), .W(W)) bus0 ();
    onehot_mux_pipe_if #(.N(N), .W(W)) bus1 ();

    assign bus1.in_data   = bus0.in_data;
    assign bus1.onehot    = bus0.onehot;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.out_ready = bus0.out_ready;

    onehot_mux_pipe #(.N(N), .W(W), .MODE(MODE_ANDOR)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0.slave),
        .clr_err    (clr_err),
        .err_sticky (err_sticky0),
        .err_cnt    (err_cnt0)
    );

    onehot_mux_pipe #(.N(N), .W(W), .MODE(MODE_PRIO)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1.slave),
        .clr_err    (clr_err),
        .err_sticky (err_sticky1),
        .err_cnt    (err_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference AND-OR selection with one-hot check.
    function automatic beat_t model(input logic [N*W-1:0] d, input logic [N-1:0] oh);
        beat_t b;
        int    hot;
        hot    = 0;
        b.data = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                b.data = b.data | d[i*W +: W];
                hot++;
            end
        end
        b.err = (hot != 1);
        return b;
    endfunction

    // One clock: compare a delivered beat, record an accepted beat, then advance.
    task automatic step();
        beat_t exp_b;
        @(negedge clk);
        if (bus0.out_valid && bus0.out_ready) begin
            check("sb_unexpected_beat", 64'(sb_q.size() == 0), 64'(0));
            if (sb_q.size() > 0) begin
                exp_b = sb_q.pop_front();
                check("sb_data", 64'(bus0.out_data), 64'(exp_b.data));
                check("sb_err", 64'(bus0.out_err), 64'(exp_b.err));
            end
        end
        if (bus0.in_valid && bus0.in_ready) sb_q.push_back(model(bus0.in_data, bus0.onehot));
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [W-1:0] val);
        bus0.in_data[idx*W +: W] = val;
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N; i++) set_word(i, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.in_data   = '0;
        bus0.onehot    = '0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(bus0.in_ready),  64'(0));
        check("rst_out_valid",  64'(bus0.out_valid), 64'(0));
        check("rst_out_data",   64'(bus0.out_data),  64'(0));
        check("rst_out_err",    64'(bus0.out_err),   64'(0));
        check("rst_err_sticky", 64'(err_sticky0),    64'(0));
        check("rst_err_cnt",    64'(err_cnt0),       64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(bus0.in_ready), 64'(1));

        // Clean one-hot select of input 1
        randomize_words();
        set_word(1, 32'hDEADBEEF);
        bus0.onehot    = 4'b0010;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        check("oh1_out_valid", 64'(bus0.out_valid), 64'(1));
        check("oh1_out_data",  64'(bus0.out_data),  64'(32'hDEADBEEF));
        check("oh1_out_err",   64'(bus0.out_err),   64'(0));
        step();
        check("oh1_drained", 64'(bus0.out_valid), 64'(0));

        // Multi-hot select: AND-OR merge vs lowest-index priority
        set_word(0, 32'h0000000F);
        set_word(1, 32'h12345678);
        set_word(2, 32'h000000F0);
        set_word(3, 32'h9ABCDEF0);
        bus0.onehot   = 4'b0101;
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        check("mh_m0_data",   64'(bus0.out_data), 64'(32'hFF));
        check("mh_m0_err",    64'(bus0.out_err),  64'(1));
        check("mh_err_cnt",   64'(err_cnt0),      64'(1));
        check("mh_sticky",    64'(err_sticky0),   64'(1));
        check("mh_m1_data",   64'(bus1.out_data), 64'(32'h0F));
        check("mh_m1_err",    64'(bus1.out_err),  64'(1));
        step();

        // Zero-hot select, then 300 of them to saturate the counter
        randomize_words();
        bus0.onehot   = 4'b0000;
        bus0.in_valid = 1'b1;
        step();
        check("zh_data", 64'(bus0.out_data), 64'(0));
        check("zh_err",  64'(bus0.out_err),  64'(1));
        for (int k = 1; k < 300; k++) begin
            randomize_words();
            step();
        end
        bus0.in_valid = 1'b0;
        step();
        check("sat_err_cnt", 64'(err_cnt0),    64'(255));
        check("sat_sticky",  64'(err_sticky0), 64'(1));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_err_cnt", 64'(err_cnt0),    64'(0));
        check("clr_sticky",  64'(err_sticky0), 64'(0));

        // Clear coinciding with an accepted bad-select beat
        bus0.onehot   = 4'b0011;
        bus0.in_valid = 1'b1;
        clr_err       = 1'b1;
        step();
        clr_err       = 1'b0;
        bus0.in_valid = 1'b0;
        check("clr_bad_err_cnt", 64'(err_cnt0),    64'(1));
        check("clr_bad_sticky",  64'(err_sticky0), 64'(1));
        step();

        // Back-pressure: A in head, B in skid, C waiting
        bus0.out_ready = 1'b0;
        randomize_words();
        set_word(0, 32'hAAAA0001);
        bus0.onehot   = 4'b0001;
        bus0.in_valid = 1'b1;
        step();
        set_word(3, 32'hBBBB0002);
        bus0.onehot = 4'b1000;
        step();
        set_word(1, 32'h0C000C00);
        set_word(2, 32'h00C000C0);
        bus0.onehot = 4'b0110;
        check("bp_in_ready",  64'(bus0.in_ready),  64'(0));
        check("bp_out_valid", 64'(bus0.out_valid), 64'(1));
        check("bp_hold_a",    64'(bus0.out_data),  64'(32'hAAAA0001));
        step();
        check("bp_stall_a",   64'(bus0.out_data),  64'(32'hAAAA0001));
        check("bp_stall_rdy", 64'(bus0.in_ready),  64'(0));
        bus0.out_ready = 1'b1;
        step();
        check("bp_head_b", 64'(bus0.out_data), 64'(32'hBBBB0002));
        step();
        bus0.in_valid = 1'b0;
        check("bp_head_c",  64'(bus0.out_data), 64'(32'h0CC00CC0));
        check("bp_c_err",   64'(bus0.out_err),  64'(1));
        check("bp_err_cnt", 64'(err_cnt0),      64'(2));
        step();
        check("bp_drained", 64'(bus0.out_valid), 64'(0));

        // Reset while full
        bus0.out_ready = 1'b0;
        bus0.onehot    = 4'b0000;
        bus0.in_valid  = 1'b1;
        step();
        step();
        bus0.in_valid = 1'b0;
        check("full_in_ready", 64'(bus0.in_ready), 64'(0));
        check("full_err_cnt",  64'(err_cnt0),      64'(4));
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(bus0.out_valid), 64'(0));
        check("arst_err_cnt",   64'(err_cnt0),       64'(0));
        check("arst_sticky",    64'(err_sticky0),    64'(0));
        check("arst_in_ready",  64'(bus0.in_ready),  64'(0));
        check("arst_out_data",  64'(bus0.out_data),  64'(0));
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        randomize_words();
        set_word(2, 32'hD00DF00D);
        bus0.onehot    = 4'b0100;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        #1;
        check("rel_in_ready", 64'(bus0.in_ready), 64'(1));
        sb_q.push_back(model(bus0.in_data, bus0.onehot));
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        check("d_out_valid", 64'(bus0.out_valid), 64'(1));
        check("d_out_data",  64'(bus0.out_data),  64'(32'hD00DF00D));
        step();
        check("d_alone", 64'(bus0.out_valid), 64'(0));

        // Drain anything left, bounded
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) step();
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
